ball_motion_scheduler: RTL

- Owns the position and direction state of NUM_BALLS bouncing balls for the sphere renderers.
- Advances all balls through one shared bounce/step datapath, one ball per cycle, in round-robin sweeps.
- A frame-tick prescaler triggers each sweep.
- Renderers read positions through a registered read port; a valid/ready port loads ball state at runtime.

---
 rtl/ball_pkg.sv | 23 ++
 rtl/ball_step.sv | 33 +++
 rtl/ball_motion_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Shared constants and the per-ball state record for the ball motion scheduler.
package ball_pkg;

  localparam int unsigned COORD_W = 7;

  localparam int unsigned H_MIN = 10;
  localparam int unsigned H_MAX = 70;
  localparam int unsigned V_MIN = 10;
  localparam int unsigned V_MAX = 50;

  localparam logic [COORD_W-1:0] RESET_POS = 7'd32;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  typedef struct packed {
    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] v;
    logic               dh;
    logic               dv;
  } ball_t;

endpackage

// File: rtl/ball_step.sv
// Combinational bounce-then-move for one ball on both axes.
module ball_step
  import ball_pkg::*;
#(
  parameter int unsigned MIN_H = H_MIN,
  parameter int unsigned MAX_H = H_MAX,
  parameter int unsigned MIN_V = V_MIN,
  parameter int unsigned MAX_V = V_MAX
) (
  input  ball_t cur,
  output ball_t nxt_c
);

  logic dh_c;
  logic dv_c;

  // Direction flips before the move so a bounce never overshoots by two.
  always_comb begin
    dh_c = cur.dh;
    dv_c = cur.dv;
    if (cur.h < COORD_W'(MIN_H))      dh_c = 1'b1;
    else if (cur.h > COORD_W'(MAX_H)) dh_c = 1'b0;
    if (cur.v < COORD_W'(MIN_V))      dv_c = 1'b1;
    else if (cur.v > COORD_W'(MAX_V)) dv_c = 1'b0;

    nxt_c    = cur;
    nxt_c.dh = dh_c;
    nxt_c.dv = dv_c;
    nxt_c.h  = dh_c ? cur.h + COORD_W'(1) : cur.h - COORD_W'(1);
    nxt_c.v  = dv_c ? cur.v + COORD_W'(1) : cur.v - COORD_W'(1);
  end

endmodule

// File: rtl/ball_motion_scheduler.sv
// Round-robin ball position updater: prescaled frame ticks trigger sweeps that
// step one ball per cycle through a shared ball_step; load and read ports on the side.
module ball_motion_scheduler
  import ball_pkg::*;
#(
  parameter int unsigned NUM_BALLS = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned CNT_W     = 21
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [CNT_W-1:0]   top,
  input  logic               init_valid,
  output logic               init_ready,
  input  logic [IDX_W-1:0]   init_idx,
  input  logic [COORD_W-1:0] init_h,
  input  logic [COORD_W-1:0] init_v,
  input  logic               init_dh,
  input  logic               init_dv,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_h,
  output logic [COORD_W-1:0] rd_v,
  output logic               busy,
  output logic               sweep_done,
  output logic               overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);

  ball_t            balls [NUM_BALLS];
  ball_t            step_c;
  logic [CNT_W-1:0] cnt;
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic             pending;
  logic             pending_nxt;
  logic             overrun_nxt;
  logic             trig_c;
  logic             load_c;
  logic             sweep_we_c;
  logic             last_c;

  assign trig_c     = frame_tick && (cnt == top);
  assign load_c     = init_valid && init_ready;
  assign sweep_we_c = (state == ST_SWEEP);
  assign last_c     = sweep_we_c && (ptr == LAST_IDX);

  ball_step u_step (
    .cur   (balls[ptr]),
    .nxt_c (step_c)
  );

  // Next-state: at most one trigger is queued behind a running sweep.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    pending_nxt = pending;
    overrun_nxt = overrun;
    case (state)
      ST_IDLE: begin
        if (trig_c || pending) begin
          state_nxt   = ST_SWEEP;
          ptr_nxt     = '0;
          pending_nxt = pending && trig_c;
        end
      end
      ST_SWEEP: begin
        ptr_nxt = ptr + IDX_W'(1);
        if (ptr == LAST_IDX) state_nxt = ST_IDLE;
        if (trig_c) begin
          if (pending) overrun_nxt = 1'b1;
          else         pending_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control registers and prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
      init_ready <= 1'b0;
      sweep_done <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      pending    <= pending_nxt;
      overrun    <= overrun_nxt;
      busy       <= (state_nxt == ST_SWEEP);
      init_ready <= (state_nxt == ST_IDLE);
      sweep_done <= last_c;
      if (frame_tick) cnt <= (cnt == top) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Ball storage and registered read port; sweep and load never overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_BALLS); i++) begin
        balls[i].h  <= RESET_POS;
        balls[i].v  <= RESET_POS;
        balls[i].dh <= 1'(i);
        balls[i].dv <= 1'(i >> 1);
      end
      rd_h <= '0;
      rd_v <= '0;
    end else begin
      rd_h <= balls[rd_idx].h;
      rd_v <= balls[rd_idx].v;
      if (sweep_we_c) begin
        balls[ptr] <= step_c;
      end else if (load_c) begin
        balls[init_idx] <= '{h: init_h, v: init_v, dh: init_dh, dv: init_dv};
      end
    end
  end

endmodule
